// File: rtl/alu_pkg.sv
// Shared opcode enum, width constants and sign-extension helper for the ALU.
// Optional status flags are enabled by defining ALU_FLAGS_EN.
package alu_pkg;

    localparam int OPW = 4;
    localparam int DW  = 4;
    localparam int AW  = 6;
    localparam int LW  = 4;

    typedef enum logic [OPW-1:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_RSUB  = 4'b0010,
        OP_INC   = 4'b0011,
        OP_DEC   = 4'b0100,
        OP_NEG   = 4'b0101,
        OP_DBL   = 4'b0110,
        OP_PASSA = 4'b0111,
        OP_AND   = 4'b1000,
        OP_OR    = 4'b1001,
        OP_XOR   = 4'b1010,
        OP_NOTA  = 4'b1011,
        OP_NAND  = 4'b1100,
        OP_NOR   = 4'b1101,
        OP_XNOR  = 4'b1110,
        OP_PASSB = 4'b1111
    } alu_op_e;

    function automatic logic [AW-1:0] sext(input logic [DW-1:0] v);
        return {{(AW-DW){v[DW-1]}}, v};
    endfunction

endpackage

// File: rtl/alu_arith.sv
// Combinational arithmetic unit: 4-bit signed operands widened to a 6-bit signed
// result, wide enough that no opcode can overflow.
module alu_arith
    import alu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    sel,
    output logic [AW-1:0] y
);

    logic [AW-1:0] w_a;
    logic [AW-1:0] w_b;
    alu_op_e       w_op;

    assign w_a  = sext(a);
    assign w_b  = sext(b);
    assign w_op = alu_op_e'({1'b0, sel});

    always_comb begin
        y = '0;
        case (w_op)
            OP_ADD:   y = w_a + w_b;
            OP_SUB:   y = w_a - w_b;
            OP_RSUB:  y = w_b - w_a;
            OP_INC:   y = w_a + 6'd1;
            OP_DEC:   y = w_a - 6'd1;
            OP_NEG:   y = 6'd0 - w_a;
            // 2*a fits in 5 bits signed, so the shift drops only a copy of the sign
            OP_DBL:   y = {w_a[AW-2:0], 1'b0} + w_b;
            OP_PASSA: y = w_a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Registered 4-bit ALU: arithmetic unit (alu_arith), logic unit, result mux and
// output registers. Define ALU_FLAGS_EN to add registered zero/neg flag outputs.
module alu_core
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        a,
    input  logic [DW-1:0]        b,
    input  logic [OPW-1:0]       sel,
`ifdef ALU_FLAGS_EN
    output logic                 zero,
    output logic                 neg,
`endif
    output logic signed [AW-1:0] y_a,
    output logic [LW-1:0]        y_l
);

    alu_op_e       w_op;
    logic          w_is_logic;
    logic [AW-1:0] w_arith;
    logic [LW-1:0] w_logic;
    logic [AW-1:0] w_y_a_next;
    logic [LW-1:0] w_y_l_next;

    assign w_op       = alu_op_e'(sel);
    assign w_is_logic = sel[OPW-1];

    alu_arith u_arith (
        .a   (a),
        .b   (b),
        .sel (sel[2:0]),
        .y   (w_arith)
    );

    always_comb begin
        w_logic = '0;
        case (w_op)
            OP_AND:   w_logic = a & b;
            OP_OR:    w_logic = a | b;
            OP_XOR:   w_logic = a ^ b;
            OP_NOTA:  w_logic = ~a;
            OP_NAND:  w_logic = ~(a & b);
            OP_NOR:   w_logic = ~(a | b);
            OP_XNOR:  w_logic = ~(a ^ b);
            OP_PASSB: w_logic = b;
            default:  w_logic = '0;
        endcase
    end

    // The inactive unit's output register is forced to zero.
    assign w_y_a_next = w_is_logic ? '0 : w_arith;
    assign w_y_l_next = w_is_logic ? w_logic : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_a <= '0;
            y_l <= '0;
        end else begin
            y_a <= w_y_a_next;
            y_l <= w_y_l_next;
        end
    end

`ifdef ALU_FLAGS_EN
    logic w_zero_next;
    logic w_neg_next;

    assign w_zero_next = w_is_logic ? (w_logic == '0) : (w_arith == '0);
    assign w_neg_next  = w_is_logic ? w_logic[LW-1] : w_arith[AW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
            neg  <= 1'b0;
        end else begin
            zero <= w_zero_next;
            neg  <= w_neg_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core with hand-computed expectations; covers the
// ALU_FLAGS_EN flag outputs when that macro is defined.
module tb_alu_core;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        a;
  logic [3:0]        b;
  logic [3:0]        sel;
  logic signed [5:0] y_a;
  logic [3:0]        y_l;
`ifdef ALU_FLAGS_EN
  logic              zero;
  logic              neg;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // a = 1, b = -5 (4'b1011)
  int         exp_arith[8] = '{-4, 6, -6, 2, 0, -1, -3, 1};
  logic [3:0] exp_log[8]   = '{4'b0001, 4'b1011, 4'b1010, 4'b1110,
                               4'b1110, 4'b0100, 4'b0101, 4'b1011};

  alu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sel   (sel),
`ifdef ALU_FLAGS_EN
    .zero  (zero),
    .neg   (neg),
`endif
    .y_a   (y_a),
    .y_l   (y_l)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int exp_a, input int exp_l);
    check_eq({tag, ".y_a"}, y_a, exp_a);
    check_eq({tag, ".y_l"}, y_l, exp_l);
  endtask

  // Drive inputs away from the edge, then land 1 time unit after the capturing edge.
  task automatic drive_op(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] iop);
    @(negedge clk);
    a   = ia;
    b   = ib;
    sel = iop;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 4'b0001;
    b     = 4'b1011;
    sel   = OP_ADD;
    #1;
    check_out("reset_initial", 0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_out("reset_held", 0, 0);
    end

    // First result appears on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("first_after_release", -4, 0);

    for (int i = 0; i < 8; i++) begin
      drive_op(4'b0001, 4'b1011, 4'(i));
      check_out($sformatf("arith_sel%0d", i), exp_arith[i], 0);
    end

    for (int i = 0; i < 8; i++) begin
      drive_op(4'b0001, 4'b1011, 4'(8 + i));
      check_out($sformatf("logic_sel%0d", 8 + i), 0, int'(exp_log[i]));
    end

    // A sel change between edges must not reach the outputs.
    @(negedge clk);
    sel = OP_ADD;
    #1;
    check_out("no_comb_path", 0, 11);
    @(posedge clk);
    #1;
    check_out("sel_change_next_edge", -4, 0);

    drive_op(4'b1000, 4'b0000, OP_NEG);
    check_out("neg_min", 8, 0);
    drive_op(4'b1000, 4'b1000, OP_DBL);
    check_out("dbl_min", -24, 0);
    drive_op(4'b1000, 4'b0111, OP_SUB);
    check_out("sub_min_max", -15, 0);
    drive_op(4'b0111, 4'b0111, OP_ADD);
    check_out("add_max", 14, 0);

    // Asynchronous clear mid-cycle, with no clock edge involved.
    drive_op(4'b0111, 4'b1000, OP_NOTA);
    check_out("pre_async", 0, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_clear", 0, 0);
    @(posedge clk);
    #1;
    check_out("in_flight_discarded", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("resume_after_async", 0, 8);

`ifdef ALU_FLAGS_EN
    drive_op(4'b0001, 4'b0001, OP_SUB);
    check_eq("flags_sub_zero.zero", int'(zero), 1);
    check_eq("flags_sub_zero.neg", int'(neg), 0);
    drive_op(4'b0001, 4'b1011, OP_ADD);
    check_eq("flags_add_neg.zero", int'(zero), 0);
    check_eq("flags_add_neg.neg", int'(neg), 1);
    drive_op(4'b0001, 4'b1011, OP_NOTA);
    check_eq("flags_nota.zero", int'(zero), 0);
    check_eq("flags_nota.neg", int'(neg), 1);
    drive_op(4'b0101, 4'b1010, OP_AND);
    check_eq("flags_and_zero.zero", int'(zero), 1);
    check_eq("flags_and_zero.neg", int'(neg), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("flags_async.zero", int'(zero), 0);
    check_eq("flags_async.neg", int'(neg), 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
